steer_en: RTL
=============

Name: steer_en

Overview:
- Rider-presence and steering-enable controller; sits directly downstream of the A2D interface and upstream of the balance controller.
- Consumes left/right load-cell readings and decides whether a rider is on the platform (rider_off) and whether steering may be enabled (en_steer).
- Requires the rider to stand balanced for about 1.34 s before en_steer asserts, and drops steering on a gross weight imbalance.
- Its en_steer and rider_off outputs are what toplevel benches check after rider step-on and step-off.

Parameters:
- FAST_SIM, 1, 1 selects a 15-bit settle timer (sim); 0 selects a 26-bit timer (2^26 clk ≈ 1.34 s at 50 MHz).
- MIN_RIDER_WT, 12'h200, nominal total rider weight threshold.
- WT_HYSTERESIS, 8'h40, hysteresis applied around MIN_RIDER_WT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- lft_ld  in  12  left load cell, unsigned
- rght_ld  in  12  right load cell, unsigned
- en_steer  out  1  steering enabled, registered
- rider_off  out  1  no rider present, registered

Behaviour:
- Reset is synchronous and active-low, single clock clk. On reset: state=IDLE, timer=0, en_steer=0, rider_off=1, pipeline registers=0.
- Stage 1 (registered every clk):
  - sum = lft_ld + rght_ld, 13-bit unsigned.
  - diff_abs = |lft_ld − rght_ld|, computed in 13-bit signed and stored as 12-bit unsigned.
- Comparators, combinational on the stage-1 registers:
  - sum_gt_min = sum > MIN_RIDER_WT + WT_HYSTERESIS (0x240)
  - sum_lt_min = sum < MIN_RIDER_WT − WT_HYSTERESIS (0x1C0)
  - diff_gt_1_4 = diff_abs > (sum>>2)
  - diff_gt_15_16 = diff_abs > (sum − (sum>>4))
  - All comparisons are unsigned, evaluated at 13 bits, with no overflow.
- Timer:
  - Free-running up-counter, width 15 or 26 per FAST_SIM.
  - Cleared by clr_tmr; otherwise increments every clk.
  - tmr_full = all ones. The timer wraps without saturating; this is harmless because WAIT exits on tmr_full.
- FSM (states IDLE, WAIT, STEER; enum):
  - IDLE: if sum_gt_min → WAIT, clr_tmr. Otherwise stay.
  - WAIT: priority order:
    - sum_lt_min → IDLE
    - else diff_gt_1_4 → stay, clr_tmr
    - else tmr_full → STEER
    - else stay
  - STEER: priority order:
    - sum_lt_min → IDLE
    - else diff_gt_15_16 → WAIT, clr_tmr
    - else stay
- Outputs, registered from next-state:
  - en_steer = (nxt==STEER)
  - rider_off = (nxt==IDLE)
- Latency:
  - Load change → comparator: 1 clk.
  - Comparator → output: 1 clk.
  - Total 2 clk.
  - Balanced rider step-on → en_steer: 2 + 2^N clk, where N=15/26.
- Boundaries:
  - sum exactly 0x240 or 0x1C0 does not trigger either comparator; the block stays in its current state (hysteresis band).
  - Sum in the band while in WAIT: the timer keeps running.
  - Simultaneous sum_lt_min and an imbalance: sum_lt_min wins.
  - Simultaneous tmr_full and diff_gt_1_4: the clear wins and the FSM stays in WAIT.
  - Reset mid-WAIT or mid-STEER: back to IDLE next clk, outputs at reset values.
  - Both cells 12'hFFF: sum 0x1FFE with no overflow.

Decomposition:
- Segway shared package holds:
  - typedef enum logic [1:0] {IDLE, WAIT, STEER} steer_state_t
  - MIN_RIDER_WT and WT_HYSTERESIS default constants
  - timer width constants for FAST and full modes
- One natural sub-module: steer_en_tmr, the parameterized clearable counter with a tmr_full output.
- The FSM and comparators stay in steer_en.

Test Plan:
- Reset, lft=rght=0 for 100 clk → rider_off=1, en_steer=0, FSM=IDLE.
- lft=rght=12'h180 (sum 0x300) held → rider_off=0 at clk 2; en_steer=1 exactly 2^15+2 clk later (FAST_SIM=1).
- In WAIT: lft=0x200, rght=0x100 (diff 0x100 > 0x300>>2=0xC0) pulsed every 20000 clk → en_steer never asserts; timer observed reset on each pulse.
- In STEER: lft=0x2F0, rght=0x010 (diff 0x2E0 > 0x2D0) → en_steer=0 within 2 clk, FSM=WAIT, rider_off=0. Then return to balanced → en_steer=1 after 2^15 clk.
- In STEER: lft=rght=0x0E8 (sum 0x1D0, in band) → en_steer stays 1. Then lft=rght=0x0D0 (sum 0x1A0) → en_steer=0, rider_off=1 within 2 clk.
- Assert rst_n=0 for 1 clk mid-STEER → next clk en_steer=0, rider_off=1. Sum 0x240 exactly from IDLE → stays IDLE.

Source files
------------

// File: rtl/steer_en_pkg.sv
// Shared types and constants for the rider-presence / steering-enable block.
// Imported by steer_en and its settle timer.
package steer_en_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STEER
  } steer_state_t;

  localparam logic [11:0] MIN_RIDER_WT_DEF  = 12'h200;
  localparam logic [7:0]  WT_HYSTERESIS_DEF = 8'h40;

  localparam int TMR_W_FAST = 15;
  localparam int TMR_W_FULL = 26;

endpackage

// File: rtl/steer_en_tmr.sv
// Clearable free-running settle timer.
// full is high while every counter bit is set; the count wraps.
module steer_en_tmr
  import steer_en_pkg::*;
#(
  parameter int W = TMR_W_FAST
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic full
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign full = &cnt;

endmodule

// File: rtl/steer_en.sv
// Rider-presence and steering-enable controller.
// Registers load sum/imbalance, then runs the IDLE/WAIT/STEER FSM.
module steer_en
  import steer_en_pkg::*;
#(
  parameter bit          FAST_SIM      = 1'b1,
  parameter logic [11:0] MIN_RIDER_WT  = MIN_RIDER_WT_DEF,
  parameter logic [7:0]  WT_HYSTERESIS = WT_HYSTERESIS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        en_steer,
  output logic        rider_off
);

  localparam int TMR_W = FAST_SIM ? TMR_W_FAST : TMR_W_FULL;

  localparam logic [12:0] THR_HI =
    {1'b0, MIN_RIDER_WT} + {5'd0, WT_HYSTERESIS};
  localparam logic [12:0] THR_LO =
    {1'b0, MIN_RIDER_WT} - {5'd0, WT_HYSTERESIS};

  logic signed [12:0] diff;
  logic        [12:0] sum;
  logic        [11:0] diff_abs;

  assign diff = $signed({1'b0, lft_ld}) - $signed({1'b0, rght_ld});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum      <= '0;
      diff_abs <= '0;
    end else begin
      sum      <= {1'b0, lft_ld} + {1'b0, rght_ld};
      diff_abs <= diff[12] ? (~diff[11:0] + 12'd1) : diff[11:0];
    end
  end

  logic sum_gt_min;
  logic sum_lt_min;
  logic diff_gt_1_4;
  logic diff_gt_15_16;

  assign sum_gt_min    = sum > THR_HI;
  assign sum_lt_min    = sum < THR_LO;
  assign diff_gt_1_4   = {1'b0, diff_abs} > (sum >> 2);
  assign diff_gt_15_16 = {1'b0, diff_abs} > (sum - (sum >> 4));

  logic clr_tmr;
  logic tmr_full;

  steer_en_tmr #(
    .W(TMR_W)
  ) u_tmr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_tmr),
    .full (tmr_full)
  );

  steer_state_t state;
  steer_state_t nxt;

  // Imbalance in WAIT restarts the settle time, even on the full cycle.
  always_comb begin
    nxt     = state;
    clr_tmr = 1'b0;
    unique case (state)
      IDLE: begin
        if (sum_gt_min) begin
          nxt     = WAIT;
          clr_tmr = 1'b1;
        end
      end
      WAIT: begin
        if (sum_lt_min) begin
          nxt = IDLE;
        end else if (diff_gt_1_4) begin
          clr_tmr = 1'b1;
        end else if (tmr_full) begin
          nxt = STEER;
        end
      end
      STEER: begin
        if (sum_lt_min) begin
          nxt = IDLE;
        end else if (diff_gt_15_16) begin
          nxt     = WAIT;
          clr_tmr = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      en_steer  <= 1'b0;
      rider_off <= 1'b1;
    end else begin
      state     <= nxt;
      en_steer  <= (nxt == STEER);
      rider_off <= (nxt == IDLE);
    end
  end

endmodule
